// File: rtl/crc32_stream_acc.sv
// crc32_stream_acc: streaming CRC-32 (IEEE 802.3, reflected) accumulator.
// Folds a framed stream of WIDTH-bit words into a running CRC using an
// unrolled byte-serial chain, supports a partial final word, and hands back
// the finished FCS plus a residue-check flag over a valid/ready handshake.
module crc32_stream_acc #(
    parameter int  WIDTH   = 64,
    localparam int EMPTY_W = $clog2(WIDTH / 8)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_crc,
    output logic               out_ok,
    output logic [15:0]        drop_cnt
);

    localparam int          NB      = WIDTH / 8;
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] SEED    = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic {IDLE, FRAME} fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] chain;     // running value while walking the byte stages
    logic [31:0] full_tap;  // state after all NB bytes
    logic [31:0] eop_tap;   // state after the last valid byte of an eop word
    logic        accept;
    logic        done;
    logic        drop;

    // One reflected byte step: xor the byte into the low bits, shift 8 times.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    // A held result blocks every input word, not just eop words; there is
    // deliberately no path from in_valid to in_ready.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Byte chain: stage k consumes byte k. A sop word always starts from the
    // seed, which also covers a sop that abandons a frame in progress. The
    // eop tap is picked after byte NB-in_empty so trailing bytes never count.
    always_comb begin
        chain   = in_sop ? SEED : crc_q;
        eop_tap = chain;
        for (int k = 0; k < NB; k++) begin
            chain = crc_byte(chain, in_data[8*k +: 8]);
            if (in_empty == EMPTY_W'(NB - 1 - k))
                eop_tap = chain;
        end
        full_tap = chain;
    end

    // Frame FSM: decides whether an accepted word updates, completes or is dropped.
    always_comb begin
        fsm_d = fsm_q;
        crc_d = crc_q;
        done  = 1'b0;
        drop  = 1'b0;
        if (accept) begin
            case (fsm_q)
                IDLE: begin
                    if (!in_sop) begin
                        drop = 1'b1;
                    end else if (in_eop) begin
                        done  = 1'b1;
                        crc_d = SEED;
                    end else begin
                        crc_d = full_tap;
                        fsm_d = FRAME;
                    end
                end
                FRAME: begin
                    if (in_eop) begin
                        done  = 1'b1;
                        crc_d = SEED;
                        fsm_d = IDLE;
                    end else begin
                        crc_d = full_tap;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    // FSM state and running CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            crc_q <= SEED;
        end else begin
            fsm_q <= fsm_d;
            crc_q <= crc_d;
        end
    end

    // Single-entry result register; a new result may load on the consuming edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_crc   <= 32'h0;
            out_ok    <= 1'b0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_crc   <= ~eop_tap;
            out_ok    <= (eop_tap == RESIDUE);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of words seen outside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= 16'h0;
        else if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'h1;
    end

endmodule
